// File: rtl/fp_mult_pkg.sv
// Shared widths and state encoding for the FP mantissa multiplier.
package fp_mult_pkg;

  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned OUT_W  = 25;
  localparam int unsigned ITER   = 24;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: accumulator, multiplicand, multiplier shift register,
// iteration counter and the truncated result register.
module mult_datapath
  import fp_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [FRAC_W-1:0] a,
  input  logic [FRAC_W-1:0] b,
  output logic [OUT_W-1:0]  out,
  output logic              last
);

  logic [PROD_W-1:0] acc;
  logic [MANT_W-1:0] mcand;
  logic [MANT_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  logic [MANT_W-1:0] addend;
  logic [MANT_W:0]   upper;
  logic [PROD_W-1:0] acc_next;

  // Add into the upper half and shift the whole accumulator right, so the
  // multiplicand never needs a wide barrel shift.
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    upper    = {1'b0, acc[PROD_W-1:MANT_W]} + {1'b0, addend};
    acc_next = {upper, acc[MANT_W-1:1]};
  end

  assign last = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      out    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {1'b1, a};
      mplier <= {1'b1, b};
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last)
        out <= acc_next[PROD_W-1:PROD_W-OUT_W];
    end
  end

endmodule

// File: rtl/mult_top.sv
// Sequential mantissa multiplier: IDLE/BUSY/DONE controller around the
// shift-add datapath, with a start/done handshake.
module mult_top
  import fp_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              startMul,
  input  logic [FRAC_W-1:0] A,
  input  logic [FRAC_W-1:0] B,
  output logic [OUT_W-1:0]  out,
  output logic              doneMul
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   step;
  logic   last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    doneMul    = 1'b0;
    case (state)
      IDLE: begin
        if (startMul) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last)
          state_next = DONE;
      end
      DONE: begin
        doneMul    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mult_datapath u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (A),
    .b    (B),
    .out  (out),
    .last (last)
  );

endmodule

// File: tb/tb_mult_top.sv
// Directed bench for mult_top with an expected-result queue.
module tb_mult_top;
  import fp_mult_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              startMul = 1'b0;
  logic [FRAC_W-1:0] A = '0;
  logic [FRAC_W-1:0] B = '0;
  logic [OUT_W-1:0]  out;
  logic              doneMul;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [OUT_W-1:0] exp_q[$];

  mult_top dut (
    .clk      (clk),
    .rst      (rst),
    .startMul (startMul),
    .A        (A),
    .B        (B),
    .out      (out),
    .doneMul  (doneMul)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model(input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b);
    logic [PROD_W-1:0] p;
    p = {24'd0, 1'b1, a} * {24'd0, 1'b1, b};
    return p[PROD_W-1:PROD_W-OUT_W];
  endfunction

  // Start one multiplication; optionally hold startMul through BUSY and
  // scramble A/B after the start edge. Checks latency, pulse width, result.
  task automatic run_mul(input string tag, input logic [FRAC_W-1:0] a,
                         input logic [FRAC_W-1:0] b, input logic [OUT_W-1:0] fixed_exp,
                         input bit hold, input bit scramble);
    int unsigned lat;
    int unsigned done_cnt;
    logic [OUT_W-1:0] e;
    @(negedge clk);
    A = a;
    B = b;
    startMul = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);  // E0
    @(negedge clk);
    if (!hold) startMul = 1'b0;
    if (scramble) begin
      A = FRAC_W'($urandom);
      B = FRAC_W'($urandom);
    end
    lat = 0;
    done_cnt = 0;
    for (int unsigned c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        A = FRAC_W'($urandom);
        B = FRAC_W'($urandom);
      end
      if (doneMul) begin
        lat = c;
        done_cnt++;
        break;
      end
    end
    startMul = 1'b0;
    check({tag, "_latency"}, 48'(lat), 48'd24);
    e = exp_q.pop_front();
    check({tag, "_model"}, 48'(out), 48'(e));
    check({tag, "_const"}, 48'(out), 48'(fixed_exp));
    @(posedge clk);  // E25
    #1;
    check({tag, "_pulse_end"}, 48'(doneMul), 48'd0);
    for (int unsigned c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (doneMul) done_cnt++;
    end
    check({tag, "_no_restart"}, 48'(done_cnt), 48'(lat == 24 ? 1 : 0));
    check({tag, "_hold_out"}, 48'(out), 48'(fixed_exp));
  endtask

  initial begin
    int unsigned spurious;
    #12;
    check("reset_out", 48'(out), 48'd0);
    check("reset_done", 48'(doneMul), 48'd0);
    @(negedge clk);
    rst = 1'b0;

    spurious = 0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (doneMul) spurious++;
    end
    check("idle_no_done", 48'(spurious), 48'd0);
    check("idle_out", 48'(out), 48'd0);

    run_mul("m15x15", 23'h400000, 23'h400000, 25'h1200000, 1'b0, 1'b0);
    run_mul("m1x1", 23'h000000, 23'h000000, 25'h0800000, 1'b0, 1'b0);
    run_mul("mmax", 23'h7FFFFF, 23'h7FFFFF, 25'h1FFFFFC, 1'b0, 1'b0);
    run_mul("mhold", 23'h400000, 23'h000000, 25'h0C00000, 1'b1, 1'b1);

    // Abort at E10 with reset; no completion may follow.
    @(negedge clk);
    A = 23'h123456;
    B = 23'h654321;
    startMul = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    startMul = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out", 48'(out), 48'd0);
    check("abort_done", 48'(doneMul), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (doneMul) spurious++;
    end
    check("abort_no_done", 48'(spurious), 48'd0);
    check("abort_out_held", 48'(out), 48'd0);

    run_mul("after_abort", 23'h123456, 23'h654321, model(23'h123456, 23'h654321), 1'b0, 1'b0);
    run_mul("mixed", 23'h2AAAAA, 23'h155555, model(23'h2AAAAA, 23'h155555), 1'b0, 1'b0);

    check("queue_empty", 48'(exp_q.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
